hci_core_sink_nd: RTL and testbench
===================================

Name: hci_core_sink_nd

Overview:
- Parametrised next-generation HWPE store streamer: takes one hwpe_stream data stream and writes it to TCDM through an hci_core master port.
- Has an integrated 2-D address generator (base, inner stride/length, outer stride).
- Generalised over data/address/length widths.
- Adds what the earlier sink lacks: byte-granular base addressing, grant-accurate completion, mid-job abort, and issue/stall counters for performance monitoring.
- Sits between an HWPE engine output stream and the HCI interconnect.

Parameters:
- DATA_WIDTH, 32, stream/TCDM data width in bits; multiple of 8, power of 2.
- ADDR_WIDTH, 32, TCDM byte-address width.
- LEN_WIDTH, 16, width of all length fields and counters.
- STALL_CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- tcdm  hci_core_intf.master  DW=DATA_WIDTH  TCDM write port.
- stream  hwpe_stream_intf_stream.sink  DATA_WIDTH  incoming data (data, strb, valid, ready).
- ctrl_i  in  hci_sink_nd_ctrl_t  req_start, abort, base_addr[ADDR_WIDTH], tot_len, d0_len, d0_stride[ADDR_WIDTH], d1_stride[ADDR_WIDTH].
- flags_o  out  hci_sink_nd_flags_t  ready_start, busy, done, aborted, issued_cnt[LEN_WIDTH], stall_cnt[STALL_CNT_WIDTH].

Behaviour:
- Reset or clear_i:
  - state IDLE; all counters 0.
  - done=0, aborted=0.
  - tcdm.req=0, stream.ready=0.
  - ready_start=1, busy=0.
- FSM states: IDLE, WORKING, DONE.
- IDLE:
  - ready_start=1.
  - On req_start, latch all ctrl fields into shadow registers, zero i0/i1/issued_cnt/stall_cnt, go to WORKING.
  - ctrl changes after start have no effect on the running job.
- WORKING:
  - busy=1.
  - tcdm.req = stream.valid & (issued_cnt < tot_len).
  - tcdm.add = cur_addr with the low log2(DATA_WIDTH/8) bits forced to 0.
  - tcdm.wen=0 (write), tcdm.be=stream.strb, tcdm.data=stream.data, tcdm.lrdy=1, boffs=0.
  - stream.ready = tcdm.gnt & (issued_cnt < tot_len). Data is consumed only on grant.
  - On each req&gnt: issued_cnt++, advance address.
  - When issued_cnt reaches tot_len, go to DONE on the next cycle.
  - tot_len==0: go straight to DONE one cycle after start; no request issued.
  - abort=1 has priority over a same-cycle grant-count update for the FSM but not for the grant itself: the granted beat counts. Go to IDLE, aborted=1 pulse for one cycle, done not asserted, tcdm.req=0 from the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE. issued_cnt and stall_cnt hold their values until the next start.
- Address generator:
  - cur_addr = base + i0*d0_stride + i1*d1_stride, built incrementally with adders only; ADDR_WIDTH wrap-around, modulo 2^ADDR_WIDTH.
  - On beat: if d0_len!=0 and i0==d0_len-1, then i0=0 and i1++; else i0++.
  - d0_len==0 means 1-D: i0 never wraps.
- stall_cnt: +1 every WORKING cycle with tcdm.req & ~tcdm.gnt; saturates at all-ones.
- Backpressure: while req & ~gnt, add/data/be stay stable. The stream protocol guarantees data stability; the address changes only on grant.
- Latency: first request combinational with stream.valid in the first WORKING cycle (one cycle after req_start). Full throughput is one beat per cycle.
- req_start while not IDLE is ignored.
- Reset mid-operation: immediate return to the reset values above; outstanding data is discarded.

Decomposition:
- hci_package gains:
  - hci_sink_nd_state_t (IDLE/WORKING/DONE).
  - hci_sink_nd_ctrl_t and hci_sink_nd_flags_t, parametrised via package localparams or sized to the maximum widths.
- Sub-module hci_sink_nd_addrgen:
  - inputs: shadowed base/strides/d0_len, start, step.
  - outputs: cur_addr, i0, i1.
  - holds its registers and incremental adders.

Test Plan:
1. Linear: base=0x100, d0_len=0, d0_stride=4, tot_len=4, gnt always 1, valid always 1 -> adds 0x100,0x104,0x108,0x10C on consecutive cycles; done pulse one cycle after the 4th grant; issued_cnt=4, stall_cnt=0.
2. 2-D: base=0, d0_len=2, d0_stride=4, d1_stride=0x40, tot_len=6 -> adds 0x0,0x4,0x40,0x44,0x80,0x84.
3. Backpressure: tot_len=2, gnt low for 3 cycles on the first beat -> req, add, data stable for 3 cycles; stream.ready=0 during the stall; stall_cnt=3; completes with issued_cnt=2.
4. Zero length: tot_len=0, start -> no tcdm.req ever; done=1 exactly at cycle start+2; ready_start back to 1 the cycle after.
5. Abort: tot_len=8, assert abort after the 3rd grant -> aborted pulse, done stays 0, issued_cnt=3, tcdm.req=0 next cycle. A new start with base=0x200 issues 0x200 first.
6. Reset/clear mid-job: rst_ni=0 (or clear_i=1) at beat 2 of 5 -> next cycle IDLE, req=0, counters 0, ready_start=1. A re-start runs cleanly to done.

Source files
------------

// File: rtl/hci_core_sink_nd_pkg.sv
// Shared types for the N-D HCI store streamer: FSM states, control and status bundles.
package hci_core_sink_nd_pkg;

  localparam int unsigned HCI_SND_ADDR_W  = 32;
  localparam int unsigned HCI_SND_LEN_W   = 16;
  localparam int unsigned HCI_SND_STALL_W = 16;
  localparam int unsigned HCI_BOFFS_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    WORKING,
    DONE
  } hci_sink_nd_state_t;

  typedef struct packed {
    logic                      req_start;
    logic                      abort;
    logic [HCI_SND_ADDR_W-1:0] base_addr;
    logic [HCI_SND_LEN_W-1:0]  tot_len;
    logic [HCI_SND_LEN_W-1:0]  d0_len;
    logic [HCI_SND_ADDR_W-1:0] d0_stride;
    logic [HCI_SND_ADDR_W-1:0] d1_stride;
  } hci_sink_nd_ctrl_t;

  typedef struct packed {
    logic                       ready_start;
    logic                       busy;
    logic                       done;
    logic                       aborted;
    logic [HCI_SND_LEN_W-1:0]   issued_cnt;
    logic [HCI_SND_STALL_W-1:0] stall_cnt;
  } hci_sink_nd_flags_t;

endpackage

// File: rtl/hci_core_sink_nd_if.sv
// TCDM master port and hwpe data stream bundles used by the N-D store streamer.
interface hci_core_intf
  import hci_core_sink_nd_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) ();
  logic                   req;
  logic                   gnt;
  logic [AW-1:0]          add;
  logic                   wen;
  logic [DW-1:0]          data;
  logic [DW/8-1:0]        be;
  logic [HCI_BOFFS_W-1:0] boffs;
  logic                   lrdy;

  modport master (output req, add, wen, data, be, boffs, lrdy, input gnt);
  modport slave  (input req, add, wen, data, be, boffs, lrdy, output gnt);
endinterface

interface hwpe_stream_intf_stream #(
  parameter int unsigned DW = 32
) ();
  logic            valid;
  logic            ready;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hci_core_sink_nd_addrgen.sv
// Incremental 2-D address generator: cur = base + i0*d0_stride + i1*d1_stride, adders only.
module hci_sink_nd_addrgen #(
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic          step_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] d0_stride_i,
  input  logic [AW-1:0] d1_stride_i,
  input  logic [LW-1:0] d0_len_i,
  output logic [AW-1:0] cur_addr_o
);

  logic [LW-1:0] i0_q, i0_d, i1_q, i1_d;
  logic [AW-1:0] line_q, line_d, cur_q, cur_d;

  // line_q tracks base + i1*d1_stride so an outer wrap restarts from the row origin
  always_comb begin
    i0_d   = i0_q;
    i1_d   = i1_q;
    line_d = line_q;
    cur_d  = cur_q;
    if (start_i) begin
      i0_d   = '0;
      i1_d   = '0;
      line_d = base_i;
      cur_d  = base_i;
    end else if (step_i) begin
      if ((d0_len_i != '0) && (i0_q == d0_len_i - LW'(1))) begin
        i0_d   = '0;
        i1_d   = i1_q + LW'(1);
        line_d = line_q + d1_stride_i;
        cur_d  = line_q + d1_stride_i;
      end else begin
        i0_d  = i0_q + LW'(1);
        cur_d = cur_q + d0_stride_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      i0_q   <= '0;
      i1_q   <= '0;
      line_q <= '0;
      cur_q  <= '0;
    end else begin
      i0_q   <= i0_d;
      i1_q   <= i1_d;
      line_q <= line_d;
      cur_q  <= cur_d;
    end
  end

  assign cur_addr_o = cur_q;

endmodule

// File: rtl/hci_core_sink_nd.sv
// HWPE store streamer: writes an incoming data stream to TCDM along a 2-D address pattern.
module hci_core_sink_nd
  import hci_core_sink_nd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = HCI_SND_ADDR_W,
  parameter int unsigned LEN_WIDTH       = HCI_SND_LEN_W,
  parameter int unsigned STALL_CNT_WIDTH = HCI_SND_STALL_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  hci_core_intf.master           tcdm,
  hwpe_stream_intf_stream.sink   stream,
  input  hci_sink_nd_ctrl_t      ctrl_i,
  output hci_sink_nd_flags_t     flags_o
);

  localparam int unsigned OFFS_W = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADD_MASK = {ADDR_WIDTH{1'b1}} << OFFS_W;

  hci_sink_nd_state_t         state_q, state_d;
  logic [LEN_WIDTH-1:0]       tot_len_q, tot_len_d, d0_len_q, d0_len_d;
  logic [LEN_WIDTH-1:0]       issued_q, issued_d;
  logic [ADDR_WIDTH-1:0]      d0_stride_q, d0_stride_d, d1_stride_q, d1_stride_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                       aborted_q, aborted_d;
  logic                       start, beat, active, req, rdy;
  logic [ADDR_WIDTH-1:0]      cur_addr;

  always_comb begin
    state_d     = state_q;
    tot_len_d   = tot_len_q;
    d0_len_d    = d0_len_q;
    d0_stride_d = d0_stride_q;
    d1_stride_d = d1_stride_q;
    issued_d    = issued_q;
    stall_d     = stall_q;
    aborted_d   = 1'b0;
    start       = 1'b0;
    beat        = 1'b0;
    req         = 1'b0;
    rdy         = 1'b0;
    active      = issued_q < tot_len_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_i.req_start) begin
          start       = 1'b1;
          tot_len_d   = ctrl_i.tot_len[LEN_WIDTH-1:0];
          d0_len_d    = ctrl_i.d0_len[LEN_WIDTH-1:0];
          d0_stride_d = ctrl_i.d0_stride[ADDR_WIDTH-1:0];
          d1_stride_d = ctrl_i.d1_stride[ADDR_WIDTH-1:0];
          issued_d    = '0;
          stall_d     = '0;
          state_d     = WORKING;
        end
      end
      WORKING: begin
        req      = stream.valid & active;
        rdy      = tcdm.gnt & active;
        beat     = req & tcdm.gnt;
        issued_d = issued_q + LEN_WIDTH'(beat);
        if (req && !tcdm.gnt && (stall_q != '1)) begin
          stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
        // a beat granted alongside abort is still counted; abort only wins the FSM
        if (ctrl_i.abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (issued_d >= tot_len_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q     <= IDLE;
      tot_len_q   <= '0;
      d0_len_q    <= '0;
      d0_stride_q <= '0;
      d1_stride_q <= '0;
      issued_q    <= '0;
      stall_q     <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tot_len_q   <= tot_len_d;
      d0_len_q    <= d0_len_d;
      d0_stride_q <= d0_stride_d;
      d1_stride_q <= d1_stride_d;
      issued_q    <= issued_d;
      stall_q     <= stall_d;
      aborted_q   <= aborted_d;
    end
  end

  // base is taken straight from ctrl_i: it is only sampled in the start cycle
  hci_sink_nd_addrgen #(
    .AW (ADDR_WIDTH),
    .LW (LEN_WIDTH)
  ) i_addrgen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start),
    .step_i      (beat),
    .base_i      (ctrl_i.base_addr[ADDR_WIDTH-1:0]),
    .d0_stride_i (d0_stride_q),
    .d1_stride_i (d1_stride_q),
    .d0_len_i    (d0_len_q),
    .cur_addr_o  (cur_addr)
  );

  assign tcdm.req     = req;
  assign tcdm.add     = cur_addr & ADD_MASK;
  assign tcdm.wen     = 1'b0;
  assign tcdm.data    = stream.data;
  assign tcdm.be      = stream.strb;
  assign tcdm.boffs   = '0;
  assign tcdm.lrdy    = 1'b1;
  assign stream.ready = rdy;

  always_comb begin
    flags_o             = '0;
    flags_o.ready_start = (state_q == IDLE);
    flags_o.busy        = (state_q == WORKING);
    flags_o.done        = (state_q == DONE);
    flags_o.aborted     = aborted_q;
    flags_o.issued_cnt  = HCI_SND_LEN_W'(issued_q);
    flags_o.stall_cnt   = HCI_SND_STALL_W'(stall_q);
  end

endmodule

// File: tb/tb_hci_core_sink_nd.sv
// Bench for hci_core_sink_nd: directed job table, corner sequences and randomized traffic vs a reference model.
module tb_hci_core_sink_nd;
  import hci_core_sink_nd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, clear;
  hci_sink_nd_ctrl_t  ctrl;
  hci_sink_nd_flags_t flags;

  hci_core_intf #(.DW(32), .AW(32)) tcdm_if ();
  hwpe_stream_intf_stream #(.DW(32)) st_if ();

  hci_core_sink_nd #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .LEN_WIDTH       (16),
    .STALL_CNT_WIDTH (16)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .tcdm    (tcdm_if),
    .stream  (st_if),
    .ctrl_i  (ctrl),
    .flags_o (flags)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt, done_cyc, start_cyc;
  logic [31:0] beat_q[$];
  logic hold;

  // reference model: job position held as a flat beat index
  int unsigned m_ph, m_iss, m_stall, m_tot, m_d0len;
  logic [31:0] m_base, m_d0s, m_d1s;
  bit m_abp;

  typedef struct packed {
    logic [31:0]       base;
    logic [15:0]       d0len;
    logic [31:0]       d0s;
    logic [31:0]       d1s;
    logic [15:0]       tot;
    logic [0:5][31:0]  adds;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic er, erd;
    logic [31:0] ea;
    int unsigned i0, i1;
    #1;
    er  = (m_ph == 1) && st_if.valid && (m_iss < m_tot);
    erd = (m_ph == 1) && tcdm_if.gnt && (m_iss < m_tot);
    i0  = (m_d0len != 0) ? m_iss % m_d0len : m_iss;
    i1  = (m_d0len != 0) ? m_iss / m_d0len : 0;
    ea  = (m_base + i0 * m_d0s + i1 * m_d1s) & 32'hFFFF_FFFC;
    chk("tcdm_req", tcdm_if.req, er);
    chk("stream_ready", st_if.ready, erd);
    if (er) begin
      chk("tcdm_add", tcdm_if.add, ea);
      chk("tcdm_data", tcdm_if.data, st_if.data);
      chk("tcdm_be", tcdm_if.be, st_if.strb);
      chk("tcdm_wen", tcdm_if.wen, 0);
    end
    chk("ready_start", flags.ready_start, m_ph == 0);
    chk("busy", flags.busy, m_ph == 1);
    chk("done", flags.done, m_ph == 2);
    chk("aborted", flags.aborted, m_abp);
    chk("issued_cnt", flags.issued_cnt, m_iss);
    chk("stall_cnt", flags.stall_cnt, m_stall);
    hold = st_if.valid && !st_if.ready;
    if (tcdm_if.req && tcdm_if.gnt) beat_q.push_back(tcdm_if.add);
    if (flags.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    if (!rst_n || clear) begin
      m_ph = 0; m_iss = 0; m_stall = 0; m_abp = 0; m_tot = 0;
    end else begin
      m_abp = 0;
      case (m_ph)
        0: if (ctrl.req_start) begin
          m_base = ctrl.base_addr; m_d0s = ctrl.d0_stride; m_d1s = ctrl.d1_stride;
          m_d0len = ctrl.d0_len; m_tot = ctrl.tot_len;
          m_iss = 0; m_stall = 0; m_ph = 1;
        end
        1: begin
          if (er && tcdm_if.gnt) m_iss++;
          if (er && !tcdm_if.gnt && m_stall < 65535) m_stall++;
          if (ctrl.abort) begin
            m_ph = 0; m_abp = 1;
          end else if (m_iss >= m_tot) m_ph = 2;
        end
        default: m_ph = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic set_job(input logic [31:0] base, input logic [15:0] d0len, input logic [31:0] d0s,
                         input logic [31:0] d1s, input logic [15:0] tot);
    ctrl.base_addr = base; ctrl.d0_len = d0len; ctrl.d0_stride = d0s;
    ctrl.d1_stride = d1s; ctrl.tot_len = tot; ctrl.req_start = 1'b1; ctrl.abort = 1'b0;
  endtask

  task automatic run_to_done();
    for (int k = 0; k < 40 && done_cnt == 0; k++) begin
      st_if.data = $urandom;
      st_if.strb = 4'($urandom);
      step();
    end
    chk("done_within_bound", done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{base: 32'h100, d0len: 16'd0, d0s: 32'h4, d1s: 32'h0, tot: 16'd4,
               adds: '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0}};
    tbl[1] = '{base: 32'h0, d0len: 16'd2, d0s: 32'h4, d1s: 32'h40, tot: 16'd6,
               adds: '{32'h0, 32'h4, 32'h40, 32'h44, 32'h80, 32'h84}};
    tbl[2] = '{base: 32'h1003, d0len: 16'd3, d0s: 32'h8, d1s: 32'h100, tot: 16'd4,
               adds: '{32'h1000, 32'h1008, 32'h1010, 32'h1100, 32'h0, 32'h0}};
    tbl[3] = '{base: 32'hFFFF_FFF8, d0len: 16'd0, d0s: 32'h4, d1s: 32'h0, tot: 16'd3,
               adds: '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0}};

    rst_n = 1'b0; clear = 1'b0; ctrl = '0; hold = 1'b0;
    tcdm_if.gnt = 1'b0; st_if.valid = 1'b0; st_if.data = '0; st_if.strb = '0;
    m_ph = 0; m_iss = 0; m_stall = 0; m_tot = 0; m_d0len = 0; m_abp = 0;
    m_base = '0; m_d0s = '0; m_d1s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();

    // directed job table, full throughput
    for (int t = 0; t < 4; t++) begin
      beat_q.delete(); done_cnt = 0;
      set_job(tbl[t].base, tbl[t].d0len, tbl[t].d0s, tbl[t].d1s, tbl[t].tot);
      tcdm_if.gnt = 1'b1; st_if.valid = 1'b1;
      start_cyc = cyc;
      step();
      ctrl.req_start = 1'b0;
      ctrl.base_addr = $urandom; ctrl.d0_stride = $urandom; ctrl.tot_len = 16'd1;
      run_to_done();
      chk("tbl_done_latency", done_cyc - start_cyc, tbl[t].tot + 1);
      chk("tbl_beats", beat_q.size(), tbl[t].tot);
      for (int k = 0; k < beat_q.size() && k < 6; k++) chk("tbl_add", beat_q[k], tbl[t].adds[k]);
      chk("tbl_issued_hold", flags.issued_cnt, tbl[t].tot);
      chk("tbl_stall_hold", flags.stall_cnt, 0);
      st_if.valid = 1'b0;
      step();
    end

    // backpressure on the first beat
    done_cnt = 0;
    set_job(32'h300, 16'd0, 32'h4, 32'h0, 16'd2);
    st_if.valid = 1'b1; st_if.data = 32'hA5A5_0001; st_if.strb = 4'h5; tcdm_if.gnt = 1'b0;
    step();
    ctrl.req_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req", tcdm_if.req, 1);
      chk("bp_add", tcdm_if.add, 32'h300);
      chk("bp_data", tcdm_if.data, 32'hA5A5_0001);
      chk("bp_ready", st_if.ready, 0);
      step();
    end
    tcdm_if.gnt = 1'b1;
    step();
    st_if.data = 32'hA5A5_0002;
    step();
    #1;
    chk("bp_done", flags.done, 1);
    chk("bp_stall_cnt", flags.stall_cnt, 3);
    chk("bp_issued", flags.issued_cnt, 2);
    step();

    // zero length
    beat_q.delete();
    set_job(32'h500, 16'd0, 32'h4, 32'h0, 16'd0);
    step();
    ctrl.req_start = 1'b0;
    #1;
    chk("zl_no_req", tcdm_if.req, 0);
    step();
    #1;
    chk("zl_done_at_start_plus_2", flags.done, 1);
    step();
    #1;
    chk("zl_ready_start", flags.ready_start, 1);
    step();
    chk("zl_no_beats", beat_q.size(), 0);

    // abort after the third grant
    set_job(32'h0, 16'd0, 32'h4, 32'h0, 16'd8);
    step();
    ctrl.req_start = 1'b0;
    repeat (3) step();
    st_if.valid = 1'b0; ctrl.abort = 1'b1;
    step();
    ctrl.abort = 1'b0; st_if.valid = 1'b1;
    #1;
    chk("ab_aborted", flags.aborted, 1);
    chk("ab_done", flags.done, 0);
    chk("ab_req", tcdm_if.req, 0);
    chk("ab_issued", flags.issued_cnt, 3);
    step();
    beat_q.delete(); done_cnt = 0;
    set_job(32'h200, 16'd0, 32'h4, 32'h0, 16'd2);
    step();
    ctrl.req_start = 1'b0;
    run_to_done();
    if (beat_q.size() > 0) chk("ab_restart_add", beat_q[0], 32'h200);
    else chk("ab_restart_beats", beat_q.size(), 2);
    step();

    // reset / clear in the middle of a job
    for (int v = 0; v < 2; v++) begin
      set_job(32'h400, 16'd0, 32'h4, 32'h0, 16'd5);
      step();
      ctrl.req_start = 1'b0;
      step();
      if (v == 0) rst_n = 1'b0; else clear = 1'b1;
      step();
      rst_n = 1'b1; clear = 1'b0;
      #1;
      chk("rc_ready_start", flags.ready_start, 1);
      chk("rc_req", tcdm_if.req, 0);
      chk("rc_issued", flags.issued_cnt, 0);
      step();
      done_cnt = 0;
      set_job(32'h400, 16'd0, 32'h4, 32'h0, 16'd5);
      step();
      ctrl.req_start = 1'b0;
      run_to_done();
      chk("rc_rerun_issued", flags.issued_cnt, 5);
      step();
    end

    // randomized traffic, ctrl churn, aborts and clears
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        st_if.valid = ($urandom % 4) != 0;
        st_if.data  = $urandom;
        st_if.strb  = 4'($urandom);
      end
      tcdm_if.gnt     = ($urandom % 3) != 0;
      ctrl.req_start  = ($urandom % 4) == 0;
      ctrl.abort      = ($urandom % 24) == 0;
      ctrl.base_addr  = $urandom;
      ctrl.tot_len    = 16'($urandom % 10);
      ctrl.d0_len     = 16'($urandom % 4);
      ctrl.d0_stride  = $urandom;
      ctrl.d1_stride  = $urandom;
      clear           = ($urandom % 150) == 0;
      step();
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
